channel: RTL and testbench

- Synthesizable point-to-point CSP rendezvous channel that carries one WIDTH-bit token from a sender process to a receiver process.
- Both sides use a two-phase (toggle) handshake. A transfer completes only when both sides have a request outstanding, so Send and Receive are blocking.
- Used as the link between pipeline blocks such as generators, merge/split and buckets, for data channels (WIDTH=8) and 1-bit control channels (WIDTH=1).

---
 rtl/channel_pkg.sv | 32 +++
 rtl/channel_fl_timer.sv | 46 ++++
 rtl/channel.sv | 157 +++++++++++++++
 tb/tb_channel.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_pkg.sv
// ----------------------------------------------------------------------------
// channel_pkg
// Shared types and constants for the CSP rendezvous channel.
//   chan_state_t        : channel state, also driven on the status port
//   CHAN_DEFAULT_WIDTH  : default token width
//   CHAN_MAX_FL         : largest supported forward-latency setting
//   chan_wait_state()   : non-transfer state implied by the pending flags
// ----------------------------------------------------------------------------
package channel_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND_WAIT = 2'd1,
      RECV_WAIT = 2'd2,
      XFER      = 2'd3
   } chan_state_t;

   localparam int CHAN_DEFAULT_WIDTH = 8;
   localparam int CHAN_MAX_FL        = 15;

   // When both sides are pending but a match is not allowed yet (leaving
   // XFER), the sender's token is reported as the one waiting.
   function automatic chan_state_t chan_wait_state(input logic s_pend,
                                                   input logic r_pend);
      chan_state_t st;
      if (s_pend)      st = SEND_WAIT;
      else if (r_pend) st = RECV_WAIT;
      else             st = IDLE;
      return st;
   endfunction

endpackage

// File: rtl/channel_fl_timer.sv
// ----------------------------------------------------------------------------
// channel_fl_timer
// Forward-latency down-counter. Loads FL on the transfer entry edge and
// counts down by one every cycle until it reaches zero.
//   clk    in  : clock
//   reset  in  : synchronous active-high reset
//   load   in  : transfer entry (match) this cycle
//   busy   out : counter not yet at zero
//   fire   out : counter reaches zero on the coming edge (ack edge)
// ----------------------------------------------------------------------------
module channel_fl_timer
   import channel_pkg::*;
#(
   parameter int FL = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic busy,
   output logic fire
);

   localparam logic [3:0] FL_LD = 4'(FL);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = FL_LD;
      else if (cnt_q != 4'd0)
         cnt_d = cnt_q - 4'd1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= 4'd0;
      else
         cnt_q <= cnt_d;
   end

   assign busy = (cnt_q != 4'd0);
   assign fire = (cnt_q == 4'd1);

endmodule

// File: rtl/channel.sv
// ----------------------------------------------------------------------------
// channel
// Point-to-point CSP rendezvous channel, two-phase handshake on both sides.
// A token moves from sender to receiver only when both have a request
// outstanding; both acks toggle on the same edge, FL cycles after the match.
//   clk, reset           : clock, synchronous active-high reset
//   send_req/send_data   : sender toggle request and token
//   send_ack             : toggles when the token has been taken
//   recv_req             : receiver toggle request
//   recv_data/recv_ack   : delivered token and its toggle ack
//   send_probe           : a Receive is pending (forced low in XFER)
//   recv_probe           : a Send is pending (forced low in XFER)
//   status               : current chan_state_t
// Optional (macro CHANNEL_STATS_EN):
//   xfer_count           : number of completed transfers (wraps)
//   stall_cycles         : cycles spent in SEND_WAIT or RECV_WAIT (wraps)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | nothing pending
// SEND_WAIT | Send pending, waiting for a Receive
// RECV_WAIT | Receive pending, waiting for a Send
// XFER      | token captured; acks toggle after FL cycles, then one exit cycle
// ----------------------------------------------------------------------------
module channel
   import channel_pkg::*;
#(
   parameter int WIDTH = CHAN_DEFAULT_WIDTH,
   parameter int FL    = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             send_req,
   input  logic [WIDTH-1:0] send_data,
   output logic             send_ack,
   input  logic             recv_req,
   output logic [WIDTH-1:0] recv_data,
   output logic             recv_ack,
   output logic             send_probe,
   output logic             recv_probe,
   output logic [1:0]       status
`ifdef CHANNEL_STATS_EN
   ,
   output logic [31:0]      xfer_count,
   output logic [31:0]      stall_cycles
`endif
);

   chan_state_t      state_q, state_d;
   logic             send_ack_q, send_ack_d;
   logic             recv_ack_q, recv_ack_d;
   logic [WIDTH-1:0] data_q, data_d;

   logic s_pend;
   logic r_pend;
   logic match;
   logic ack_tgl;
   logic tmr_busy;
   logic tmr_fire;

   assign s_pend = send_req ^ send_ack_q;
   assign r_pend = recv_req ^ recv_ack_q;

   // No new match while a transfer is still in XFER, which gives the
   // one-transfer-per-two-cycles rate at FL=0.
   assign match = (state_q != XFER) && s_pend && r_pend;

   generate
      if (FL == 0) begin : g_no_fl
         assign tmr_busy = 1'b0;
         assign tmr_fire = 1'b0;
         assign ack_tgl  = match;
      end else begin : g_fl
         channel_fl_timer #(
            .FL (FL)
         ) u_fl_timer (
            .clk   (clk),
            .reset (reset),
            .load  (match),
            .busy  (tmr_busy),
            .fire  (tmr_fire)
         );
         assign ack_tgl = (state_q == XFER) && tmr_fire;
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      send_ack_d = send_ack_q;
      recv_ack_d = recv_ack_q;
      data_d     = data_q;

      if (match) begin
         data_d  = send_data;
         state_d = XFER;
      end else if (state_q == XFER) begin
         if (!tmr_busy)
            state_d = chan_wait_state(s_pend, r_pend);
      end else begin
         state_d = chan_wait_state(s_pend, r_pend);
      end

      if (ack_tgl) begin
         send_ack_d = ~send_ack_q;
         recv_ack_d = ~recv_ack_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         send_ack_q <= 1'b0;
         recv_ack_q <= 1'b0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         send_ack_q <= send_ack_d;
         recv_ack_q <= recv_ack_d;
         data_q     <= data_d;
      end
   end

   assign send_ack   = send_ack_q;
   assign recv_ack   = recv_ack_q;
   assign recv_data  = data_q;
   assign status     = state_q;
   assign send_probe = r_pend && (state_q != XFER);
   assign recv_probe = s_pend && (state_q != XFER);

`ifdef CHANNEL_STATS_EN
   logic [31:0] xfer_count_q, xfer_count_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      xfer_count_d   = xfer_count_q;
      stall_cycles_d = stall_cycles_q;
      if (ack_tgl)
         xfer_count_d = xfer_count_q + 32'd1;
      if ((state_q == SEND_WAIT) || (state_q == RECV_WAIT))
         stall_cycles_d = stall_cycles_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         xfer_count_q   <= 32'd0;
         stall_cycles_q <= 32'd0;
      end else begin
         xfer_count_q   <= xfer_count_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign xfer_count   = xfer_count_q;
   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_channel.sv
// ----------------------------------------------------------------------------
// tb_channel
// Bench for channel: an 8-bit FL=0 instance and a 1-bit FL=2 instance.
// Stats checks are compiled in when CHANNEL_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_channel;

   logic       clk = 1'b0;
   logic       reset;

   // 8-bit, FL=0 instance
   logic       s_req, r_req;
   logic [7:0] s_data;
   logic       s_ack, r_ack, s_probe, r_probe;
   logic [7:0] r_data;
   logic [1:0] st;

   // 1-bit, FL=2 instance
   logic       f_s_req, f_r_req;
   logic [0:0] f_s_data;
   logic       f_s_ack, f_r_ack, f_s_probe, f_r_probe;
   logic [0:0] f_r_data;
   logic [1:0] f_st;

`ifdef CHANNEL_STATS_EN
   logic [31:0] xfer_cnt, stall_cnt, f_xfer_cnt, f_stall_cnt;
`endif

   int nchecks = 0;
   int nerrors = 0;

   // expected ack levels (both acks of a channel always move together)
   logic ea0 = 1'b0;
   logic ea1 = 1'b0;

   always #5 clk = ~clk;

   channel #(.WIDTH(8), .FL(0)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .send_req   (s_req),
      .send_data  (s_data),
      .send_ack   (s_ack),
      .recv_req   (r_req),
      .recv_data  (r_data),
      .recv_ack   (r_ack),
      .send_probe (s_probe),
      .recv_probe (r_probe),
      .status     (st)
`ifdef CHANNEL_STATS_EN
      ,
      .xfer_count   (xfer_cnt),
      .stall_cycles (stall_cnt)
`endif
   );

   channel #(.WIDTH(1), .FL(2)) u_dut_fl (
      .clk        (clk),
      .reset      (reset),
      .send_req   (f_s_req),
      .send_data  (f_s_data),
      .send_ack   (f_s_ack),
      .recv_req   (f_r_req),
      .recv_data  (f_r_data),
      .recv_ack   (f_r_ack),
      .send_probe (f_s_probe),
      .recv_probe (f_r_probe),
      .status     (f_st)
`ifdef CHANNEL_STATS_EN
      ,
      .xfer_count   (f_xfer_cnt),
      .stall_cycles (f_stall_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchecks++;
      assert (obs === exp)
      else begin
         nerrors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int          ds, dr, m, km;
      logic [7:0]  tok;
      bit          post_xfer;

      reset   = 1'b1;
      s_req   = 1'b0; r_req   = 1'b0; s_data   = 8'h00;
      f_s_req = 1'b0; f_r_req = 1'b0; f_s_data = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();

      // ---------------- reset state ----------------
      chk("rst_send_ack", s_ack, 1'b0);
      chk("rst_recv_ack", r_ack, 1'b0);
      chk("rst_recv_data", r_data, 8'h00);
      chk("rst_status", st, 2'd0);
      chk("rst_fl_status", f_st, 2'd0);
      chk("rst_fl_data", f_r_data, 1'b0);

      // ---------------- send first ----------------
      s_data = 8'hA5;
      s_req  = ~s_req;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("sf_status", st, 2'd1);
         chk("sf_recv_probe", r_probe, 1'b1);
         chk("sf_send_probe", s_probe, 1'b0);
         chk("sf_ack_hold", s_ack, ea0);
      end
      r_req = ~r_req;
      tick();
      ea0 = ~ea0;
      chk("sf_data", r_data, 8'hA5);
      chk("sf_send_ack", s_ack, ea0);
      chk("sf_recv_ack", r_ack, ea0);
      chk("sf_status_xfer", st, 2'd3);
      chk("sf_probe_xfer", r_probe, 1'b0);
      tick();
      chk("sf_status_idle", st, 2'd0);

      // ---------------- receive first ----------------
      r_req = ~r_req;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rf_status", st, 2'd2);
         chk("rf_send_probe", s_probe, 1'b1);
         chk("rf_ack_hold", r_ack, ea0);
      end
      s_data = 8'h3C;
      s_req  = ~s_req;
      tick();
      ea0 = ~ea0;
      chk("rf_data", r_data, 8'h3C);
      chk("rf_send_ack", s_ack, ea0);
      chk("rf_recv_ack", r_ack, ea0);
      tick();
      chk("rf_status_idle", st, 2'd0);

      // ---------------- simultaneous, back-to-back ----------------
      for (int t = 1; t <= 4; t++) begin
         s_data = 8'(t);
         s_req  = ~s_req;
         r_req  = ~r_req;
         tick();
         ea0 = ~ea0;
         chk("b2b_data", r_data, 64'(t));
         chk("b2b_send_ack", s_ack, ea0);
         chk("b2b_recv_ack", r_ack, ea0);
         s_data = ~8'(t);
         tick();
         chk("b2b_data_hold", r_data, 64'(t));
         chk("b2b_ack_hold", s_ack, ea0);
      end

      // ---------------- withdrawal ----------------
      s_req = ~s_req;
      tick();
      chk("wd_send_wait", st, 2'd1);
      s_req = ~s_req;
      tick();
      chk("wd_send_idle", st, 2'd0);
      chk("wd_send_probe", r_probe, 1'b0);
      r_req = ~r_req;
      tick(); tick();
      chk("wd_recv_wait", st, 2'd2);
      r_req = ~r_req;
      tick();
      chk("wd_recv_idle", st, 2'd0);
      chk("wd_recv_probe", s_probe, 1'b0);
      chk("wd_ack_hold", s_ack, ea0);
      chk("wd_data_hold", r_data, 8'h04);

      // ---------------- randomized rendezvous ----------------
      // Each side posts after a random delay counted from the last ack edge.
      // The match happens once both are pending, but never on the edge right
      // after an ack edge; with FL=0 the acks toggle on the match edge.
      post_xfer = 1'b0;
      for (int n = 0; n < 40; n++) begin
         ds  = int'($urandom_range(0, 4));
         dr  = int'($urandom_range(0, 4));
         tok = 8'($urandom);
         m   = (ds > dr) ? ds : dr;
         km  = (post_xfer && m < 1) ? 1 : m;
         s_data = 8'($urandom);
         for (int k = 0; k <= km; k++) begin
            if (k == ds) begin
               s_data = tok;
               s_req  = ~s_req;
            end
            if (k == dr)
               r_req = ~r_req;
            tick();
            if (k < km) begin
               chk("rnd_send_ack_hold", s_ack, ea0);
               chk("rnd_recv_ack_hold", r_ack, ea0);
               chk("rnd_recv_probe", r_probe, (k >= ds));
               chk("rnd_send_probe", s_probe, (k >= dr));
            end else begin
               ea0 = ~ea0;
               chk("rnd_send_ack", s_ack, ea0);
               chk("rnd_recv_ack", r_ack, ea0);
               chk("rnd_data", r_data, tok);
               chk("rnd_probe_xfer", r_probe | s_probe, 1'b0);
            end
         end
         post_xfer = 1'b1;
      end
      tick();

      // ---------------- WIDTH=1, FL=2 ----------------
      for (int i = 0; i < 2; i++) begin
         f_s_data = (i == 0) ? 1'b1 : 1'b0;
         f_s_req  = ~f_s_req;
         f_r_req  = ~f_r_req;
         tick();
         chk("fl_status_xfer", f_st, 2'd3);
         chk("fl_data_capture", f_r_data, f_s_data);
         chk("fl_ack_wait0", f_s_ack, ea1);
         f_s_data = ~f_s_data;
         tick();
         chk("fl_ack_wait1", f_r_ack, ea1);
         chk("fl_probe_xfer", f_s_probe | f_r_probe, 1'b0);
         tick();
         ea1 = ~ea1;
         chk("fl_send_ack", f_s_ack, ea1);
         chk("fl_recv_ack", f_r_ack, ea1);
         chk("fl_data", f_r_data, (i == 0) ? 1'b1 : 1'b0);
         tick();
         chk("fl_status_idle", f_st, 2'd0);
      end

      // ---------------- reset mid-operation ----------------
      s_data   = 8'hFF;
      s_req    = ~s_req;
      f_s_data = 1'b1;
      f_s_req  = ~f_s_req;
      f_r_req  = ~f_r_req;
      tick();
      chk("mr_pending", st, 2'd1);
      chk("mr_fl_xfer", f_st, 2'd3);
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      s_req   = 1'b0; r_req   = 1'b0;
      f_s_req = 1'b0; f_r_req = 1'b0;
      ea0 = 1'b0; ea1 = 1'b0;
      tick();
      chk("mr_send_ack", s_ack, 1'b0);
      chk("mr_recv_ack", r_ack, 1'b0);
      chk("mr_recv_data", r_data, 8'h00);
      chk("mr_status", st, 2'd0);
      chk("mr_fl_data", f_r_data, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mr_no_ack", {s_ack, r_ack, f_s_ack, f_r_ack}, 4'b0000);
         chk("mr_fl_status", f_st, 2'd0);
      end

`ifdef CHANNEL_STATS_EN
      // ---------------- stats: 5 transfers, 2 stall cycles each ----------------
      chk("st_rst_xfer", xfer_cnt, 32'd0);
      chk("st_rst_stall", stall_cnt, 32'd0);
      for (int n = 0; n < 5; n++) begin
         s_data = 8'(n + 16);
         s_req  = ~s_req;
         tick(); tick();
         r_req = ~r_req;
         tick();
         ea0 = ~ea0;
         chk("st_data", r_data, 64'(n + 16));
         tick();
      end
      chk("st_xfer_count", xfer_cnt, 32'd5);
      chk("st_stall_cycles", stall_cnt, 32'd10);
`endif

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
